// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image from a byte channel into a word-write instruction RAM.
// Latency: RAM write one cycle after the 4th byte of each word; byte_ready is low in WRITE/IDLE/DONE/ERROR so the source holds its byte.
module imem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] WORDS = 17'(MEM_SIZE / 4);

  if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_size
    $error("imem_loader: MEM_SIZE must be a power of two greater than 4");
  end

  state_t      state;
  state_t      state_nxt;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] lanes;
  logic        xfer;
  logic [15:0] len_full;

  assign xfer     = byte_valid & byte_ready;
  // Full length as it will stand once the high byte lands this cycle.
  assign len_full = {byte_in, word_cnt[7:0]};

  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (len_full == 16'd0)            state_nxt = DONE;
          else if ({1'b0, len_full} > WORDS) state_nxt = ERROR;
          else                              state_nxt = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (xfer && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (word_idx == word_cnt - 16'd1) state_nxt = DONE;
        else                              state_nxt = DATA;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      lanes    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        LEN_LO: begin
          if (xfer) word_cnt[7:0] <= byte_in;
        end
        LEN_HI: begin
          if (xfer) begin
            word_cnt[15:8] <= byte_in;
            word_idx       <= '0;
            byte_cnt       <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            if (byte_cnt == 2'd3) begin
              // Write port is loaded here so it holds steady through WRITE and afterwards.
              wr_data  <= {byte_in, lanes};
              wr_addr  <= {46'd0, word_idx, 2'b00};
              byte_cnt <= 2'd0;
            end else begin
              lanes[{byte_cnt, 3'b000} +: 8] <= byte_in;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected RAM writes, one task per scenario.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.MEM_SIZE(1024)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   wr_cyc_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   n_writes   = 0;
  int   n_xfers    = 0;
  logic [63:0] last_addr;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every observed write must match the next expected one.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) n_xfers++;
    if (wr_en) begin
      n_writes++;
      last_addr = wr_addr;
      wr_cyc_q.push_back(cyc);
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          mismatched++;
          $display("FAIL write: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
      compared++;
      if (byte_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL ready_in_write: got byte_ready=%b, expected 0", byte_ready);
      end
    end
  end

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk) byte_valid = 1'b0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    waited     = 0;
    while (!byte_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      mismatched++;
      compared++;
      $display("FAIL byte_timeout: byte_ready never rose for byte %02h, expected 1", b);
    end else begin
      @(posedge clk);
    end
    #1 byte_valid = 1'b0;
  endtask

  // Sends header and words; each word is pushed to the scoreboard as it is driven.
  task automatic send_image(input logic [31:0] words[$], input bit gaps);
    send_byte(8'(words.size()), gaps);
    send_byte(8'(words.size() >> 8), gaps);
    for (int i = 0; i < words.size(); i++) begin
      wr_t e;
      e.addr = 64'(i * 4);
      e.data = words[i];
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], gaps);
    end
  endtask

  task automatic wait_done(input string name);
    int w;
    w = 0;
    while (done !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_done: got done=%b, expected 1", name, done);
    end
    compared++;
    if (cpu_hold !== 1'b0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_end: got cpu_hold=%b pending=%0d, expected cpu_hold=0 pending=0",
               name, cpu_hold, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; byte_valid = 1'b1; byte_in = 8'hA5;
    repeat (3) @(negedge clk);
    compared++;
    if ({cpu_hold, done, error, byte_ready, wr_en} !== 5'b10000 || wr_addr !== 64'd0 || wr_data !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got hold/done/err/rdy/wen=%b addr=%0h data=%0h, expected 10000 0 0",
               {cpu_hold, done, error, byte_ready, wr_en}, wr_addr, wr_data);
    end
    reset_n = 1'b1;
    byte_valid = 1'b0;
    repeat (5) @(negedge clk);
    compared++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || n_writes != 0) begin
      mismatched++;
      $display("FAIL idle_after_reset: got rdy=%b hold=%b writes=%0d, expected 0 1 0",
               byte_ready, cpu_hold, n_writes);
    end
  endtask

  task automatic test_two_word();
    logic [31:0] img[$];
    img = '{32'hD2800013, 32'h14000000};
    wr_cyc_q.delete();
    do_start();
    send_image(img, 1'b0);
    wait_done("two_word");
    compared++;
    if (wr_cyc_q.size() != 2 || wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
      mismatched++;
      $display("FAIL two_word_spacing: got %0d writes gap=%0d, expected 2 writes gap=5",
               wr_cyc_q.size(), wr_cyc_q.size() == 2 ? wr_cyc_q[1] - wr_cyc_q[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] img[$];
    img = '{32'hD2800013, 32'h14000000};
    do_start();
    compared++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL reload_hold: got hold=%b done=%b, expected 1 0", cpu_hold, done);
    end
    n_xfers = 0;
    send_image(img, 1'b1);
    wait_done("backpressure");
    compared++;
    if (n_xfers != 10) begin
      mismatched++;
      $display("FAIL byte_count: got %0d, expected 10", n_xfers);
    end
  endtask

  task automatic test_capacity();
    logic [31:0] img[$];
    int w0;
    for (int i = 0; i < 256; i++) img.push_back($urandom());
    w0 = n_writes;
    do_start();
    send_image(img, 1'b0);
    wait_done("full");
    compared++;
    if (n_writes - w0 != 256 || last_addr !== 64'd1020) begin
      mismatched++;
      $display("FAIL full_ram: got %0d writes last_addr=%0d, expected 256 1020", n_writes - w0, last_addr);
    end
    w0 = n_writes;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (4) @(negedge clk);
    compared++;
    if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_hold !== 1'b1 || n_writes != w0) begin
      mismatched++;
      $display("FAIL over_capacity: got err=%b rdy=%b hold=%b writes=%0d, expected 1 0 1 0",
               error, byte_ready, cpu_hold, n_writes - w0);
    end
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || error !== 1'b0 || n_writes != w0) begin
      mismatched++;
      $display("FAIL zero_len: got done=%b err=%b writes=%0d, expected 1 0 0", done, error, n_writes - w0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] img[$];
    wr_t e;
    int w0;
    w0 = n_writes;
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    e.addr = 64'd0; e.data = 32'hCAFEF00D;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_byte(e.data[8*k +: 8], 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk) reset_n = 1'b0;
    #1;
    compared++;
    if (byte_ready !== 1'b0 || cpu_hold !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: got rdy=%b hold=%b wen=%b done=%b, expected 0 1 0 0",
               byte_ready, cpu_hold, wr_en, done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (n_writes - w0 != 1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL mid_reset_writes: got %0d writes pending=%0d, expected 1 0", n_writes - w0, exp_q.size());
    end
    img = '{32'h01234567, 32'h89ABCDEF};
    do_start();
    send_image(img, 1'b0);
    wait_done("after_reset");
  endtask

  task automatic test_start_ignored();
    wr_t e;
    int w0;
    w0 = n_writes;
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    e.addr = 64'd0; e.data = 32'h55AA33CC;
    exp_q.push_back(e);
    for (int k = 0; k < 4; k++) send_byte(e.data[8*k +: 8], 1'b0);
    e.addr = 64'd4; e.data = 32'h0BADBEEF;
    exp_q.push_back(e);
    send_byte(e.data[7:0], 1'b0);
    do_start();
    for (int k = 1; k < 4; k++) send_byte(e.data[8*k +: 8], 1'b0);
    wait_done("start_ignored");
    compared++;
    if (n_writes - w0 != 2) begin
      mismatched++;
      $display("FAIL start_ignored_count: got %0d writes, expected 2", n_writes - w0);
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_backpressure();
    test_capacity();
    test_reset_mid_load();
    test_start_ignored();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: streams a program image in over a byte-wide valid/ready channel and writes it into a writable instruction RAM.
- The RAM is a 32-bit word-write / 32-bit combinational-read replacement for the file-initialized ROM.
- Holds the CPU in stall while loading. Lets benchmarks be swapped at run time instead of at elaboration.
- Sits between a host/UART byte source and the RAM write port. The CPU fetch path stays on the RAM read port.

Parameters:
- MEM_SIZE, 1024, RAM size in bytes. Must be a power of two and > 4. Word capacity is MEM_SIZE/4.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- byte_in  in  8  incoming stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts byte_in this cycle. Transfer occurs when byte_valid & byte_ready.
- wr_en  out  1  RAM word-write strobe, one cycle per word.
- wr_addr  out  64  RAM byte address, always word-aligned (bits [1:0]=0).
- wr_data  out  32  RAM write data.
- cpu_hold  out  1  CPU stall / PC-reset request.
- done  out  1  level: image fully written.
- error  out  1  level: header length exceeds capacity.

Behaviour:
- Stream format:
  - 2-byte little-endian word count N (16-bit).
  - Then 4*N bytes, each word little-endian: first byte → wr_data[7:0], fourth byte → [31:24].
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- Reset (async, reset_n=0): state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0. Internal word index, byte counter and N all cleared.
- IDLE: byte_ready=0, cpu_hold=1. On start → LEN_LO.
- LEN_LO: byte_ready=1. On transfer, latch N[7:0] → LEN_HI.
- LEN_HI: byte_ready=1. On transfer, latch N[15:8], then decide next state from the full 16-bit N:
  - N=0 → DONE.
  - N > MEM_SIZE/4 → ERROR.
  - else → DATA, with word index=0 and byte counter=0.
- DATA: byte_ready=1. Each transfer shifts the byte into its lane, selected by the byte counter. On the 4th byte → WRITE.
- WRITE: byte_ready=0. wr_en=1 for exactly one cycle, wr_addr=word_index*4, wr_data=assembled word. Next cycle:
  - if word_index==N-1 → DONE;
  - else word_index+1 → DATA.
- Word write latency: wr_en is asserted the cycle after the 4th byte's handshake. Peak throughput is 4 bytes per 5 cycles.
- DONE: cpu_hold=0, done=1, byte_ready=0. Held until start (→ LEN_LO, done cleared same edge) or reset.
- ERROR: error=1, cpu_hold=1, byte_ready=0, no writes. Leaves only on start (→ LEN_LO, error cleared) or reset.
- start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- wr_en is never asserted outside WRITE.
- wr_addr+3 < MEM_SIZE is guaranteed by the capacity check. N=MEM_SIZE/4 is legal and fills the RAM exactly; no wrap-around.
- byte_valid with byte_ready=0 causes no state change. The byte is not consumed; the source holds it.
- Stalls of any length mid-word are legal. Partial word state is kept.
- reset_n asserted mid-load: immediate return to IDLE, no wr_en glitch. RAM contents from completed words remain.
- wr_data/wr_addr keep their last values outside WRITE.
- cpu_hold rises the cycle after start is sampled in DONE.

Test Plan:
- Reset/idle: hold reset_n=0 with byte_valid=1 → cpu_hold=1, done=0, error=0, byte_ready=0. After release with no start → still IDLE, no wr_en.
- Two-word load: start; bytes 02 00, 13 00 80 D2, 00 00 00 14, valid every cycle → two wr_en pulses:
  - addr 0 data 0xD2800013;
  - addr 4 data 0x14000000, asserted 5 cycles apart;
  - then done=1, cpu_hold=0.
- Backpressure/gaps: same image with byte_valid toggled randomly → identical writes and values. Byte count consumed exactly 10. byte_ready=0 in each WRITE cycle.
- Capacity boundaries, MEM_SIZE=1024:
  - N=256 → 256 writes, last wr_addr=1020, done=1.
  - N=257 (01 01) → error=1, zero writes, byte_ready=0.
  - N=0 → done=1 immediately after 2 header bytes.
- Reset mid-load: reset_n=0 after 2 of 4 data bytes of word 1 → no wr_en for word 1, state IDLE, cpu_hold=1. Fresh start plus full image loads correctly.
- Reload/start rules: start in DONE → cpu_hold=1, done=0, second image written over the first. start asserted during DATA → ignored, word count unchanged.
